// File: rtl/bellek_dma.sv
// Word-by-word memory-to-memory copy engine driving a single-port RAM with a registered read port.
// Optional running checksum of written words is enabled by defining BELLEK_DMA_CHECKSUM_EN.
module bellek_dma #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    output logic          aborted,
    output logic [AW:0]   count,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_d,
    output logic          mem_we,
    input  logic [DW-1:0] mem_q
`ifdef BELLEK_DMA_CHECKSUM_EN
    ,
    output logic [DW-1:0] checksum
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t        state;
    logic [AW-1:0] src_reg;
    logic [AW-1:0] dst_reg;
    logic [AW:0]   len_reg;
    logic [AW:0]   count_inc;

    assign count_inc = count + 1'b1;

    // The RAM read port already holds the word fetched in READ, so it feeds the write data directly.
    assign mem_d = mem_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            src_reg <= '0;
            dst_reg <= '0;
            len_reg <= '0;
            count   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            aborted <= 1'b0;
            mem_a   <= '0;
            mem_we  <= 1'b0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            case (state)
                IDLE: begin
                    mem_we <= 1'b0;
                    if (start) begin
                        src_reg <= src;
                        dst_reg <= dst;
                        len_reg <= len;
                        count   <= '0;
                        busy    <= 1'b1;
                        if (len != '0) begin
                            state <= READ;
                            mem_a <= src;
                        end else begin
                            state <= FIN;
                            done  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (abort) begin
                        state   <= FIN;
                        aborted <= 1'b1;
                    end else begin
                        state  <= WRITE;
                        mem_a  <= dst_reg + count[AW-1:0];
                        mem_we <= 1'b1;
                    end
                end
                WRITE: begin
                    // The write in this cycle always lands, even when abort is raised.
                    count  <= count_inc;
                    mem_we <= 1'b0;
                    if (abort) begin
                        state   <= FIN;
                        aborted <= 1'b1;
                    end else if (count_inc == len_reg) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end else begin
                        state <= READ;
                        mem_a <= src_reg + count_inc[AW-1:0];
                    end
                end
                FIN: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    mem_we <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

`ifdef BELLEK_DMA_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if (state == IDLE && start) begin
            checksum <= '0;
        end else if (state == WRITE) begin
            checksum <= checksum + mem_q;
        end
    end
`endif

endmodule

// File: tb/tb_bellek_dma.sv
// Directed bench for bellek_dma: behavioural RAM with registered read, write monitor, pulse counters.
module tb_bellek_dma;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [7:0]  src;
    logic [7:0]  dst;
    logic [8:0]  len;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [8:0]  count;
    logic [7:0]  mem_a;
    logic [31:0] mem_d;
    logic        mem_we;
    logic [31:0] mem_q;
`ifdef BELLEK_DMA_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    logic [31:0] mem [256];
    int n_checks = 0;
    int n_pass   = 0;
    int edge_n   = 0;
    int start_edge = 0;
    int done_at  = -1;
    int done_cnt = 0;
    int abrt_cnt = 0;
    int wr_cnt   = 0;
    int wr_bad   = 0;
    int lo = 0;
    int hi = 255;

    bellek_dma #(.AW(8), .DW(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .src     (src),
        .dst     (dst),
        .len     (len),
        .busy    (busy),
        .done    (done),
        .aborted (aborted),
        .count   (count),
        .mem_a   (mem_a),
        .mem_d   (mem_d),
        .mem_we  (mem_we),
        .mem_q   (mem_q)
`ifdef BELLEK_DMA_CHECKSUM_EN
        ,
        .checksum(checksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM: read data refreshes only on non-write cycles.
    always @(posedge clk) begin
        if (mem_we === 1'b1) mem[mem_a] <= mem_d;
        else                 mem_q <= mem[mem_a];
    end

    always @(posedge clk) begin
        edge_n++;
        if (mem_we === 1'b1) begin
            wr_cnt++;
            if (int'(mem_a) < lo || int'(mem_a) > hi) wr_bad++;
        end
    end

    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            if (done_at < 0) done_at = edge_n - start_edge;
        end
        if (aborted === 1'b1) abrt_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic launch(input logic [7:0] s, input logic [7:0] d, input logic [8:0] l);
        src = s; dst = d; len = l; start = 1'b1;
        done_cnt = 0; abrt_cnt = 0; wr_cnt = 0; wr_bad = 0; done_at = -1;
        start_edge = edge_n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy === 1'b1 && k < 600) begin
            @(negedge clk);
            k++;
        end
        check(tag, {63'd0, busy}, 64'd0);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; src = '0; dst = '0; len = '0;
        for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
        for (int i = 0; i < 4; i++) mem[i] <= 32'(i + 1);
        for (int i = 0; i < 6; i++) mem[250 + i] <= 32'h100 + 32'(i);
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_abrt", {63'd0, aborted}, 64'd0);
        check("rst_we", {63'd0, mem_we}, 64'd0);
        check("rst_count", {55'd0, count}, 64'd0);
        check("rst_mem_a", {56'd0, mem_a}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic 4-word copy 0..3 -> 16..19
        lo = 16; hi = 19;
        launch(8'd0, 8'd16, 9'd4);
        check("t1_busy", {63'd0, busy}, 64'd1);
        wait_idle("t1_timeout");
        for (int i = 0; i < 4; i++) check($sformatf("t1_mem%0d", 16 + i), {32'd0, mem[16 + i]}, 64'(i + 1));
        check("t1_count", {55'd0, count}, 64'd4);
        check("t1_done_at", 64'(done_at), 64'd9);
        check("t1_done_cnt", 64'(done_cnt), 64'd1);
        check("t1_writes", 64'(wr_cnt), 64'd4);
        check("t1_wr_bad", 64'(wr_bad), 64'd0);
`ifdef BELLEK_DMA_CHECKSUM_EN
        check("t1_checksum", {32'd0, checksum}, 64'd10);
`endif

        // Source wraps past 255
        lo = 5; hi = 14;
        launch(8'd250, 8'd5, 9'd10);
        wait_idle("t2_timeout");
        for (int i = 0; i < 10; i++)
            check($sformatf("t2_mem%0d", 5 + i), {32'd0, mem[5 + i]},
                  (i < 6) ? 64'(32'h100 + 32'(i)) : 64'(i - 5));
        check("t2_mem4", {32'd0, mem[4]}, 64'd0);
        check("t2_mem15", {32'd0, mem[15]}, 64'd0);
        check("t2_count", {55'd0, count}, 64'd10);
        check("t2_writes", 64'(wr_cnt), 64'd10);
        check("t2_wr_bad", 64'(wr_bad), 64'd0);
        check("t2_done_cnt", 64'(done_cnt), 64'd1);
`ifdef BELLEK_DMA_CHECKSUM_EN
        check("t2_checksum", {32'd0, checksum}, 64'h619);
`endif

        // Zero-length request
        lo = 0; hi = -1;
        launch(8'd0, 8'd40, 9'd0);
        wait_idle("t3_timeout");
        check("t3_writes", 64'(wr_cnt), 64'd0);
        check("t3_count", {55'd0, count}, 64'd0);
        check("t3_done_cnt", 64'(done_cnt), 64'd1);
        check("t3_done_in_2", {63'd0, (done_at >= 1 && done_at <= 2)}, 64'd1);

        // Abort in third WRITE of an 8-word copy
        lo = 32; hi = 34;
        launch(8'd0, 8'd32, 9'd8);
        repeat (5) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_idle("t4_timeout");
        check("t4_count", {55'd0, count}, 64'd3);
        check("t4_abrt_cnt", 64'(abrt_cnt), 64'd1);
        check("t4_done_cnt", 64'(done_cnt), 64'd0);
        check("t4_writes", 64'(wr_cnt), 64'd3);
        check("t4_wr_bad", 64'(wr_bad), 64'd0);
        check("t4_mem34", {32'd0, mem[34]}, 64'd3);
        check("t4_mem35", {32'd0, mem[35]}, 64'd0);

        // Asynchronous reset during the second WRITE
        lo = 64; hi = 64;
        launch(8'd0, 8'd64, 9'd8);
        repeat (3) @(negedge clk);
        check("t5_we_before", {63'd0, mem_we}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_we_async", {63'd0, mem_we}, 64'd0);
        check("t5_busy_async", {63'd0, busy}, 64'd0);
        check("t5_count_async", {55'd0, count}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_writes", 64'(wr_cnt), 64'd1);
        check("t5_wr_bad", 64'(wr_bad), 64'd0);
        check("t5_mem65", {32'd0, mem[65]}, 64'd0);
        check("t5_pulses", 64'(done_cnt + abrt_cnt), 64'd0);
        lo = 80; hi = 83;
        launch(8'd0, 8'd80, 9'd4);
        wait_idle("t5b_timeout");
        for (int i = 0; i < 4; i++) check($sformatf("t5b_mem%0d", 80 + i), {32'd0, mem[80 + i]}, 64'(i + 1));
        check("t5b_done_cnt", 64'(done_cnt), 64'd1);

        // Second start while busy is ignored
        lo = 96; hi = 99;
        launch(8'd0, 8'd96, 9'd4);
        @(negedge clk);
        src = 8'd250; dst = 8'd200; len = 9'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("t6_timeout");
        for (int i = 0; i < 4; i++) check($sformatf("t6_mem%0d", 96 + i), {32'd0, mem[96 + i]}, 64'(i + 1));
        check("t6_count", {55'd0, count}, 64'd4);
        check("t6_writes", 64'(wr_cnt), 64'd4);
        check("t6_wr_bad", 64'(wr_bad), 64'd0);
        check("t6_done_cnt", 64'(done_cnt), 64'd1);
        check("t6_mem200", {32'd0, mem[200]}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
